// File: rtl/rvx_priority_arbiter_seq_if.sv
// Request/grant bundle between requesters and the priority arbiter.
// The master side drives requests, lock and the accept strobe.
// The slave side (the arbiter) returns the held grant.
interface rvx_priority_arbiter_seq_if #(
    parameter int NUM_REQ = 4
);
    localparam int INDEX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     req;
    logic                   lock;
    logic                   grant_ready;
    logic                   grant_valid;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [INDEX_WIDTH-1:0] grant_index;

    modport master (
        output req,
        output lock,
        output grant_ready,
        input  grant_valid,
        input  grant_onehot,
        input  grant_index
    );

    modport slave (
        input  req,
        input  lock,
        input  grant_ready,
        output grant_valid,
        output grant_onehot,
        output grant_index
    );
endinterface

// File: rtl/rvx_priority_arbiter_seq.sv
// Registered find-first-set arbiter with fixed-LSB, fixed-MSB or round-robin
// priority. The grant is held until accepted. An accept with lock keeps the
// same requester for the next grant when it is still requesting.
// A synchronous clear drops the grant and rewinds the round-robin pointer.
module rvx_priority_arbiter_seq #(
    parameter int NUM_REQ       = 4,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    rvx_priority_arbiter_seq_if.slave bus
);
    localparam int INDEX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] grantIdx_q, grantIdx_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

    logic                   accept;
    logic                   keepLocked;
    logic [INDEX_WIDTH-1:0] ptrWrap;
    logic [INDEX_WIDTH-1:0] ptrAfter;
    logic [NUM_REQ-1:0]     maskReq;
    logic [INDEX_WIDTH-1:0] loIdx;
    logic [INDEX_WIDTH-1:0] hiIdx;
    logic [INDEX_WIDTH-1:0] maskLoIdx;
    logic [INDEX_WIDTH-1:0] winIdx;
    logic                   winFound;

    // Accept qualification, lock retention test and the pointer value that the next arbitration will use.
    always_comb begin
        accept     = (state_q == GRANT) && bus.grant_ready;
        keepLocked = bus.lock && bus.req[grantIdx_q];
        if (grantIdx_q == INDEX_WIDTH'(NUM_REQ - 1)) begin
            ptrWrap = '0;
        end else begin
            ptrWrap = grantIdx_q + 1'b1;
        end
        ptrAfter = ptr_q;
        if ((PRIORITY_MODE == 2) && accept && !bus.lock) begin
            ptrAfter = ptrWrap;
        end
    end

    // Find-first-set winner selection on the live request vector.
    always_comb begin
        maskReq   = '0;
        loIdx     = '0;
        hiIdx     = '0;
        maskLoIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            maskReq[i] = bus.req[i] && (INDEX_WIDTH'(i) >= ptrAfter);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                loIdx = INDEX_WIDTH'(i);
            end
            if (maskReq[i]) begin
                maskLoIdx = INDEX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) begin
                hiIdx = INDEX_WIDTH'(i);
            end
        end
        winFound = |bus.req;
        case (PRIORITY_MODE)
            0:       winIdx = loIdx;
            1:       winIdx = hiIdx;
            default: winIdx = (|maskReq) ? maskLoIdx : loIdx;
        endcase
    end

    // State, held winner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= IDLE;
            grantIdx_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            grantIdx_q <= grantIdx_d;
            ptr_q      <= ptr_d;
        end
    end

    // Next-state logic: start a grant, hold it, retain it under lock, re-arbitrate on accept, or fall idle.
    always_comb begin
        state_d    = state_q;
        grantIdx_d = grantIdx_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (winFound) begin
                    state_d    = GRANT;
                    grantIdx_d = winIdx;
                end
            end
            GRANT: begin
                if (accept) begin
                    ptr_d = ptrAfter;
                    if (keepLocked) begin
                        grantIdx_d = grantIdx_q;
                    end else if (winFound) begin
                        grantIdx_d = winIdx;
                    end else begin
                        state_d    = IDLE;
                        grantIdx_d = '0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                grantIdx_d = '0;
            end
        endcase
        if (clear) begin
            state_d    = IDLE;
            grantIdx_d = '0;
            ptr_d      = '0;
        end
    end

    // Grant outputs: everything reads zero unless a grant is held.
    always_comb begin
        bus.grant_valid  = (state_q == GRANT);
        bus.grant_index  = '0;
        bus.grant_onehot = '0;
        if (state_q == GRANT) begin
            bus.grant_index = grantIdx_q;
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.grant_onehot[i] = (INDEX_WIDTH'(i) == grantIdx_q);
            end
        end
    end
endmodule
